// File: rtl/keccak_dbg_pkg.sv
// ----------------------------------------------------------------------------
// keccak_dbg_pkg : shared geometry defaults, slice type and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keccak_dbg_pkg;

  localparam int SLICE_W_DEF    = 25;
  localparam int NUM_SLICES_DEF = 64;

  typedef logic [SLICE_W_DEF-1:0] slice_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/slice_mux.sv
// ----------------------------------------------------------------------------
// slice_mux : combinational indexed slice select from a flattened state
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slice_mux
  import keccak_dbg_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF,
  parameter int IDX_W      = $clog2(NUM_SLICES)
) (
  input  logic [SLICE_W*NUM_SLICES-1:0] state_i,
  input  logic [IDX_W-1:0]              idx_i,
  output logic [SLICE_W-1:0]            slice_o
);

  always_comb begin
    slice_o = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx_i == IDX_W'(i)) begin
        slice_o = state_i[i*SLICE_W +: SLICE_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/keccak_state_streamer.sv
// ----------------------------------------------------------------------------
// keccak_state_streamer : snapshot a Keccak state, stream it one slice/beat
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keccak_state_streamer
  import keccak_dbg_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF,
  parameter int TAG_W      = 10,
  parameter int REVERSE    = 0,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cap_valid,
  output logic                          cap_ready,
  input  logic [TAG_W-1:0]              cap_tag,
  input  logic [SLICE_W*NUM_SLICES-1:0] cap_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W-1:0]            out_data,
  output logic [$clog2(NUM_SLICES)-1:0] out_index,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_last,
  output logic                          done,
  output logic [CNT_W-1:0]              dump_count
);

  localparam int IDX_W = $clog2(NUM_SLICES);
  localparam logic [IDX_W-1:0] c_first_idx = (REVERSE != 0) ? IDX_W'(NUM_SLICES-1) : '0;
  localparam logic [IDX_W-1:0] c_last_idx  = (REVERSE != 0) ? '0 : IDX_W'(NUM_SLICES-1);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [SLICE_W*NUM_SLICES-1:0]   snap_q;
  logic [TAG_W-1:0]                tag_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [SLICE_W-1:0]              w_slice;
  logic                            w_cap_fire;
  logic                            w_at_last;

  assign w_cap_fire = cap_valid && cap_ready;
  assign w_at_last  = (idx_q == c_last_idx);

  slice_mux #(
    .SLICE_W    (SLICE_W),
    .NUM_SLICES (NUM_SLICES),
    .IDX_W      (IDX_W)
  ) u_slice_mux (
    .state_i (snap_q),
    .idx_i   (idx_q),
    .slice_o (w_slice)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (w_cap_fire) begin
        tag_q <= cap_tag;
      end
      if (state_q == DONE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Snapshot needs no reset: outputs are blanked whenever not streaming.
  always_ff @(posedge clk) begin
    if (w_cap_fire) begin
      snap_q <= cap_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_ready = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        cap_ready = !rst;
        if (cap_valid && !rst) begin
          idx_d   = c_first_idx;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (w_at_last) begin
            state_d = DONE;
          end else if (REVERSE != 0) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data   = out_valid ? w_slice : '0;
  assign out_index  = out_valid ? idx_q   : '0;
  assign out_tag    = out_valid ? tag_q   : '0;
  assign out_last   = out_valid && w_at_last;
  assign dump_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_keccak_state_streamer.sv
// ----------------------------------------------------------------------------
// tb_keccak_state_streamer : scoreboard bench, forward and reverse instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keccak_state_streamer;

  localparam int SW = 25;
  localparam int NS = 64;
  localparam int TW = 10;
  localparam int CW = 16;

  typedef struct packed {
    logic [SW-1:0] data;
    logic [5:0]    idx;
    logic [TW-1:0] tag;
    logic          last;
    logic          inst;
  } beat_t;

  typedef struct {
    int          k;
    logic [TW-1:0] tag;
    int          pat;
    int          mode;
    int          exp_cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [TW-1:0]    cap_tag = '0;
  logic [SW*NS-1:0] cap_data = '0;
  logic             cv   [2];
  logic             cr   [2];
  logic             ov   [2];
  logic             ordy [2];
  logic [SW-1:0]    od   [2];
  logic [5:0]       oi   [2];
  logic [TW-1:0]    ot   [2];
  logic             ol   [2];
  logic             dn   [2];
  logic [CW-1:0]    dc   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    keccak_state_streamer #(
      .SLICE_W(SW), .NUM_SLICES(NS), .TAG_W(TW), .REVERSE(g), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cap_valid(cv[g]), .cap_ready(cr[g]), .cap_tag(cap_tag), .cap_data(cap_data),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]), .out_index(oi[g]),
      .out_tag(ot[g]), .out_last(ol[g]), .done(dn[g]), .dump_count(dc[g])
    );
  end

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    ncap [2], nbeats [2], ndone [2], cap_cyc [2], last_cyc [2];
  bit    pend_done [2], stall_prev [2], cap_prev [2];
  beat_t held [2];
  beat_t sbq [$];
  vec_t  vecs [5];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [SW*NS-1:0] make_data(int pat);
    logic [SW*NS-1:0] d;
    d = '0;
    for (int i = 0; i < NS; i++) d[i*SW +: SW] = (pat == 0) ? SW'(i) : SW'($urandom);
    return d;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  task automatic mon_step();
    beat_t cur, exp;
    cyc++;
    if (rst) sbq.delete();
    for (int k = 0; k < 2; k++) begin
      cur.data = od[k]; cur.idx = oi[k]; cur.tag = ot[k]; cur.last = ol[k]; cur.inst = (k == 1);
      if (rst) begin
        pend_done[k] = 0; stall_prev[k] = 0; cap_prev[k] = 0;
        continue;
      end
      if (pend_done[k] || dn[k]) check($sformatf("done_pulse%0d", k), 64'(dn[k]), 64'(pend_done[k]));
      if (dn[k]) ndone[k]++;
      pend_done[k] = 0;
      if (cap_prev[k]) check($sformatf("first_beat_latency%0d", k), 64'(ov[k]), 64'(1));
      cap_prev[k] = 0;
      if (stall_prev[k]) begin
        check($sformatf("stall_valid%0d", k), 64'(ov[k]), 64'(1));
        check($sformatf("stall_hold%0d", k), 64'(cur), 64'(held[k]));
      end
      if (cv[k] && cr[k]) begin
        for (int j = 0; j < NS; j++) begin
          int i;
          i = (k == 1) ? NS - 1 - j : j;
          exp.data = cap_data[i*SW +: SW]; exp.idx = 6'(i); exp.tag = cap_tag;
          exp.last = (j == NS - 1); exp.inst = (k == 1);
          sbq.push_back(exp);
        end
        ncap[k]++; cap_cyc[k] = cyc; cap_prev[k] = 1;
      end
      if (ov[k] && ordy[k]) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_beat%0d: got beat %h, want no beat", k, cur);
        end else begin
          exp = sbq.pop_front();
          check($sformatf("beat%0d", k), 64'(cur), 64'(exp));
          if (exp.last) begin pend_done[k] = 1; last_cyc[k] = cyc; end
        end
        nbeats[k]++;
      end
      stall_prev[k] = ov[k] && !ordy[k];
      held[k] = cur;
    end
  endtask

  task automatic drive_ready(int k, int mode, inout int ph);
    bit pat4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    case (mode)
      1:       ordy[k] = 1'($urandom_range(0, 1));
      2:       ordy[k] = pat4[ph % 4];
      default: ordy[k] = 1'b1;
    endcase
    ph++;
  endtask

  task automatic run_dump(int k, logic [TW-1:0] tag, int pat, int mode, int exp_cnt);
    int c0, d0, b0, ph;
    bit ok;
    c0 = ncap[k]; d0 = ndone[k]; b0 = nbeats[k]; ph = 0; ok = 0;
    @(posedge clk); #1;
    cap_tag = tag; cap_data = make_data(pat); cv[k] = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      if (ncap[k] != c0) cv[k] = 1'b0;
      drive_ready(k, mode, ph);
      if (ndone[k] != d0) begin ok = 1; break; end
    end
    cv[k] = 1'b0;
    ordy[k] = 1'b1;
    check($sformatf("dump_completed%0d", k), 64'(ok), 64'(1));
    check($sformatf("beat_count%0d", k), 64'(nbeats[k] - b0), 64'(NS));
    @(negedge clk);
    check($sformatf("dump_count%0d", k), 64'(dc[k]), 64'(exp_cnt));
  endtask

  initial begin
    int b0, c0, d0, gap;
    bit ok;
    vecs[0] = '{k: 0, tag: 10'h007, pat: 0, mode: 0, exp_cnt: 2};
    vecs[1] = '{k: 0, tag: 10'h3FF, pat: 1, mode: 1, exp_cnt: 3};
    vecs[2] = '{k: 0, tag: 10'h155, pat: 1, mode: 2, exp_cnt: 4};
    vecs[3] = '{k: 1, tag: 10'h007, pat: 0, mode: 0, exp_cnt: 1};
    vecs[4] = '{k: 1, tag: 10'h2AA, pat: 1, mode: 1, exp_cnt: 2};
    for (int k = 0; k < 2; k++) begin
      cv[k] = 0; ordy[k] = 1; ncap[k] = 0; nbeats[k] = 0; ndone[k] = 0;
      cap_cyc[k] = 0; last_cyc[k] = 0; pend_done[k] = 0; stall_prev[k] = 0; cap_prev[k] = 0;
    end
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    // Reset: held three cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cap_ready_in_reset0", 64'(cr[0]), 64'(0));
    check("cap_ready_in_reset1", 64'(cr[1]), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_outputs%0d", k),
            64'({ov[k], ol[k], dn[k], dc[k], od[k], oi[k], ot[k]}), 64'(0));
      check($sformatf("cap_ready_after_reset%0d", k), 64'(cr[k]), 64'(1));
    end

    // Reset while the 21st beat (index 20) is presented.
    b0 = nbeats[0]; c0 = ncap[0]; d0 = ndone[0]; ok = 0;
    @(posedge clk); #1;
    cap_tag = 10'h011; cap_data = make_data(1); cv[0] = 1'b1; ordy[0] = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      if (ncap[0] != c0) cv[0] = 1'b0;
      if (nbeats[0] - b0 == 20) begin ok = 1; break; end
    end
    check("reach_beat20", 64'(ok), 64'(1));
    check("index_at_abort", 64'(oi[0]), 64'(20));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("valid_after_abort", 64'(ov[0]), 64'(0));
    check("done_after_abort", 64'(dn[0]), 64'(0));
    check("count_after_abort", 64'(dc[0]), 64'(0));
    repeat (4) @(negedge clk);
    check("no_done_pulse_after_abort", 64'(ndone[0] - d0), 64'(0));

    // Fresh dump after the abort restarts from index 0.
    run_dump(0, 10'h005, 0, 0, 1);

    for (int v = 0; v < 5; v++)
      run_dump(vecs[v].k, vecs[v].tag, vecs[v].pat, vecs[v].mode, vecs[v].exp_cnt);

    // Capture isolation: cap_valid held high, cap_data churning during STREAM.
    c0 = ncap[0]; d0 = ndone[0]; gap = -1; ok = 0;
    @(posedge clk); #1;
    cap_tag = 10'h0AB; cap_data = make_data(0); cv[0] = 1'b1; ordy[0] = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(posedge clk); #1;
      if (ncap[0] - c0 >= 2) begin gap = cap_cyc[0] - last_cyc[0]; ok = 1; break; end
      cap_data = make_data(1);
    end
    cv[0] = 1'b0;
    check("second_capture_seen", 64'(ok), 64'(1));
    check("back_to_back_gap", 64'(gap), 64'(2));
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      @(posedge clk); #1;
      if (ndone[0] - d0 >= 2) begin ok = 1; break; end
    end
    check("isolation_dumps_done", 64'(ok), 64'(1));
    @(negedge clk);
    check("isolation_dump_count", 64'(dc[0]), 64'(6));
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keccak_state_streamer.md
Name: keccak_state_streamer

Overview:
- Captures a full Keccak state snapshot (NUM_SLICES slices of SLICE_W bits) on a valid/ready request, then streams it out one slice per beat over a valid/ready output channel.
- Each beat carries the slice index and the request tag (round/file index).
- Sits between the encoder datapath (after rho/pi/chi/iota stages) and the simulation dump sink or an on-chip debug buffer.
- Generalises per-stage state dumping: configurable geometry and slice order, backpressure, a tag field and completion bookkeeping.

Parameters:
- SLICE_W, 25, bits per slice (one 5x5 plane).
- NUM_SLICES, 64, slices per state; state width = SLICE_W*NUM_SLICES.
- TAG_W, 10, width of request tag.
- REVERSE, 0, 0 = emit slice 0 (bits [SLICE_W-1:0]) first; 1 = emit slice NUM_SLICES-1 first.
- CNT_W, 16, width of completed-dump counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cap_valid  in  1  snapshot request
- cap_ready  out  1  block can accept a snapshot
- cap_tag  in  TAG_W  tag for request
- cap_data  in  SLICE_W*NUM_SLICES  state to capture
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  SLICE_W  current slice
- out_index  out  $clog2(NUM_SLICES)  slice index of beat
- out_tag  out  TAG_W  tag of snapshot being streamed
- out_last  out  1  final beat of snapshot
- done  out  1  one-cycle pulse after last beat accepted
- dump_count  out  CNT_W  number of completed dumps

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - out_valid=0, out_last=0, done=0, dump_count=0, out_data=0, out_index=0, out_tag=0.
  - cap_ready=0 during the reset cycle, 1 from the first cycle after rst deasserts.
- Reset mid-stream aborts the snapshot immediately: no done pulse, dump_count not incremented.
- States: IDLE, STREAM, DONE.
- IDLE:
  - cap_ready=1, out_valid=0.
  - On cap_valid&&cap_ready: latch cap_data into the snapshot register and cap_tag into the tag register.
  - Load idx = REVERSE ? NUM_SLICES-1 : 0, then go to STREAM.
  - First beat is valid on the cycle after the capture edge (latency 1).
- STREAM:
  - cap_ready=0; requests are held by the source, never dropped.
  - out_valid=1.
  - out_data = snapshot[idx*SLICE_W +: SLICE_W]; out_index = idx.
  - out_last=1 when idx is the final index (NUM_SLICES-1, or 0 if REVERSE).
  - On out_valid&&out_ready: if not last, idx steps +1 (or -1 if REVERSE). If last, go to DONE.
  - With out_ready=0, all out_* signals hold stable (AXI-style).
  - The snapshot register must not change while streaming, even if cap_data changes.
- DONE (one cycle):
  - done=1, out_valid=0, cap_ready=0.
  - dump_count increments, wrapping modulo 2^CNT_W.
  - Next state is IDLE.
  - A back-to-back request is therefore accepted at the earliest 2 cycles after the last handshake.
- No arithmetic beyond the index counter. idx never leaves [0, NUM_SLICES-1].
- Simultaneous rst and any handshake: rst wins.

Decomposition:
- Shared package keccak_dbg_pkg holds:
  - constants SLICE_W_DEF=25, NUM_SLICES_DEF=64
  - typedef slice_t (logic [SLICE_W-1:0])
  - state enum {IDLE, STREAM, DONE}
- One natural sub-module, slice_mux: a combinational indexed slice select from the snapshot. It is reusable by other debug taps.
- A separate simulation-only consumer, state_dump_sink, accepts the stream and writes one binary line per beat to "<tag>_<stage>.txt". It belongs to the testbench, not to this block.

Test Plan:
- Reset values: rst for 3 cycles, then release -> all outputs 0; cap_ready=1 on the first post-reset cycle.
- Single dump, REVERSE=0: cap_data slice i = i (25-bit), tag=7, out_ready=1 -> 64 consecutive beats, out_data=out_index=0..63, out_last only on beat 63, out_tag=7, done one cycle later, dump_count=1.
- Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly -> out_data/out_index/out_last stable while stalled; no beat lost or duplicated; exactly 64 accepted beats.
- REVERSE=1 with the same data -> beats 63 down to 0, out_last on index 0.
- Capture isolation: cap_data changes and cap_valid held high during STREAM -> streamed data is the original snapshot. The second request is accepted 2 cycles after the first last beat, and dump_count reaches 2.
- Reset mid-stream at beat 20 -> out_valid=0 the next cycle, no done, dump_count unchanged. A new dump then completes normally from index 0.
